proc_ele_mslot: RTL
===================

# proc_ele_mslot

Parametrised processing element for the systolic array. It generalises the two-slot weight-stationary PE to an NSLOT-deep weight bank, selectable signed or unsigned arithmetic, and a widened accumulator. It adds an output-stationary mode with a local accumulator closed by a last-beat flag. It sits at every grid point of the array: A flows east, B/weights flow south, partial sums flow south or drain from the local accumulator.

## Interface
- WIDTH, 8, operand width of A and B
- NSLOT, 4, weight-bank depth (power of two, ≥2); SW = $clog2(NSLOT)
- ACCW, 2*WIDTH+4, accumulator / partial-sum width (≥ 2*WIDTH+1)
- SIGNED, 0, 1 = two's-complement operands and sums, 0 = unsigned
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS)
- ain / ain_slot / ain_val / ain_last  in  WIDTH / SW / 1 / 1  A operand, bank select, valid, last beat of an OS dot product
- bin / bin_slot / bin_val  in  WIDTH / SW / 1  weight, bank index, valid
- cin / cin_val  in  ACCW / 1  partial sum from north, valid
- aout / aout_slot / aout_val / aout_last  out  WIDTH / SW / 1 / 1  registered A forward
- bout / bout_slot / bout_val  out  WIDTH / SW / 1  registered B forward
- cout / cout_val  out  ACCW / 1  result, valid
- sat  out  1  sticky saturation flag (see Configuration)

## Operation
- Product: prod = ain * bank[ain_slot], 2*WIDTH bits; sign-extended (SIGNED=1) or zero-extended to ACCW.
- Weight bank: if bin_val, bank[bin_slot] <= bin. bout <= bank[bin_slot] (pre-write content), bout_slot <= bin_slot, bout_val <= bin_val. This makes the south chain a shift-load: the PE keeps the newest weight and pushes the previous one down.
- A forward: aout, aout_slot, aout_val, aout_last <= inputs every cycle, unconditionally.
- WS mode: if ain_val, cout <= (cin_val ? cin : 0) + prod; else cout holds. cout_val <= ain_val. ain_last is ignored; acc stays 0.
- OS mode:
  - ain_val & !ain_last: acc <= acc + prod; cout_val <= 0.
  - ain_val & ain_last: cout <= acc + prod, cout_val <= 1, acc <= 0.
  - !ain_val & cin_val: cout <= cin, cout_val <= 1 (drain pass-through from north).
  - Collision (ain_val & ain_last & cin_val): the local result wins and cin is lost. The array controller guarantees no collision; the bench flags any collision as an error.
- Mode change: on any cycle where mode differs from its registered value, acc <= 0. mode changes only between tiles; any in-flight OS sum is discarded.
- Arithmetic wraps modulo 2^ACCW unless PE_SAT_EN is defined.

## Timing
- Reset (async assert, sync deassert upstream): aout, aout_slot, aout_val, aout_last, bout, bout_slot, bout_val, cout, cout_val, sat = 0; bank all 0; acc = 0; registered mode = 0.
- Every output is registered, with latency 1 cycle from the inputs.
- Same-cycle bank write and A read of the same slot: the product uses the old weight.
- Same-cycle write and bout read of the same slot: bout carries the old weight.
- Reset asserted mid-dot-product clears acc immediately; the partial result is never emitted.
- There is no backpressure; downstream always accepts.

## Configuration
- PE_SAT_EN defined: each WS or OS addition clamps to the ACCW range (signed: −2^(ACCW−1)…2^(ACCW−1)−1; unsigned: 0…2^ACCW−1). Any clamp sets sat = 1, which stays set until reset.
- PE_SAT_EN undefined: additions wrap; sat is tied to 0 and no clamp logic is built.

## Test plan
- Bank load, NSLOT=4, WIDTH=8: bin=1,2,3,4 into slots 0..3 over 4 cycles, then slot 0 rewritten with 9 -> bout=1 one cycle after the rewrite; A reads of slots 0..3 return weights 9,2,3,4.
- WS, unsigned: bank[2]=5, ain=7 slot 2, cin=100, cin_val=1 -> cout=135, cout_val=1 after 1 cycle; with cin_val=0 -> cout=35.
- WS, SIGNED=1: bank[1]=−3, ain=−4, cin=−20 -> cout=−8; ain=−128 × bank=−128 -> cout=16384 with no wrap (ACCW=20).
- OS: mode=1, ain=1..4 against bank[0]=2, ain_last on the 4th beat -> single cout=20 with cout_val=1; acc=0 afterwards. A cin_val pulse with cin=77 on an idle cycle -> cout=77.
- Reset mid-OS after 2 beats, then a fresh 3-beat product of 1s against weight 1 -> cout=3 (not 5); all outputs are 0 during reset.
- PE_SAT_EN, ACCW=17, unsigned: cin=0x1FFFF plus prod=1 -> cout=0x1FFFF, sat=1 and sticky. Without PE_SAT_EN -> cout=0, sat=0.

Source files
------------

// File: rtl/proc_ele_mslot_if.sv
// Bus bundle for one systolic processing element: east/south forward paths and result.
// i_* signals flow into the PE (slave), o_* signals flow out of it.
interface proc_ele_mslot_if #(
  parameter int WIDTH = 8,
  parameter int NSLOT = 4,
  parameter int ACCW  = 2*WIDTH+4
);
  localparam int SW = $clog2(NSLOT);

  logic             i_mode;
  logic [WIDTH-1:0] i_ain;
  logic [SW-1:0]    i_ain_slot;
  logic             i_ain_val;
  logic             i_ain_last;
  logic [WIDTH-1:0] i_bin;
  logic [SW-1:0]    i_bin_slot;
  logic             i_bin_val;
  logic [ACCW-1:0]  i_cin;
  logic             i_cin_val;

  logic [WIDTH-1:0] o_aout;
  logic [SW-1:0]    o_aout_slot;
  logic             o_aout_val;
  logic             o_aout_last;
  logic [WIDTH-1:0] o_bout;
  logic [SW-1:0]    o_bout_slot;
  logic             o_bout_val;
  logic [ACCW-1:0]  o_cout;
  logic             o_cout_val;
  logic             o_sat;

  modport master (
    output i_mode, i_ain, i_ain_slot, i_ain_val, i_ain_last,
           i_bin, i_bin_slot, i_bin_val, i_cin, i_cin_val,
    input  o_aout, o_aout_slot, o_aout_val, o_aout_last,
           o_bout, o_bout_slot, o_bout_val, o_cout, o_cout_val, o_sat
  );

  modport slave (
    input  i_mode, i_ain, i_ain_slot, i_ain_val, i_ain_last,
           i_bin, i_bin_slot, i_bin_val, i_cin, i_cin_val,
    output o_aout, o_aout_slot, o_aout_val, o_aout_last,
           o_bout, o_bout_slot, o_bout_val, o_cout, o_cout_val, o_sat
  );
endinterface

// File: rtl/proc_ele_mslot.sv
// Multi-slot systolic PE: NSLOT weight bank, weight-stationary or output-stationary MAC.
// Define PE_SAT_EN to clamp additions to the ACCW range and raise the sticky sat flag.
module proc_ele_mslot #(
  parameter int WIDTH  = 8,
  parameter int NSLOT  = 4,
  parameter int ACCW   = 2*WIDTH+4,
  parameter int SIGNED = 0
) (
  input logic             clk,
  input logic             rst_n,
  proc_ele_mslot_if.slave bus
);
  localparam int SW  = $clog2(NSLOT);
  localparam int PW  = 2*WIDTH;
  localparam bit SGN = (SIGNED != 0);

  logic [WIDTH-1:0] r_bank [NSLOT];
  logic [ACCW-1:0]  r_acc;
  logic             r_mode;
  logic [WIDTH-1:0] r_aout;
  logic [SW-1:0]    r_aout_slot;
  logic             r_aout_val;
  logic             r_aout_last;
  logic [WIDTH-1:0] r_bout;
  logic [SW-1:0]    r_bout_slot;
  logic             r_bout_val;
  logic [ACCW-1:0]  r_cout;
  logic             r_cout_val;

  logic [WIDTH-1:0] w_weight;
  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_w_ext;
  logic [PW-1:0]    w_prod;
  logic [ACCW-1:0]  w_prodx;
  logic             w_mode_chg;
  logic [ACCW-1:0]  w_acc_eff;
  logic [ACCW-1:0]  w_opnd;
  logic [ACCW-1:0]  w_sum;

  // The bank read sees the pre-write weight, so a same-cycle rewrite never leaks into the product.
  assign w_weight  = r_bank[bus.i_ain_slot];
  assign w_a_ext   = {{WIDTH{SGN & bus.i_ain[WIDTH-1]}}, bus.i_ain};
  assign w_w_ext   = {{WIDTH{SGN & w_weight[WIDTH-1]}}, w_weight};
  assign w_prod    = w_a_ext * w_w_ext;
  assign w_prodx   = {{(ACCW-PW){SGN & w_prod[PW-1]}}, w_prod};

  assign w_mode_chg = bus.i_mode != r_mode;
  assign w_acc_eff  = w_mode_chg ? '0 : r_acc;
  assign w_opnd     = bus.i_mode ? w_acc_eff : (bus.i_cin_val ? bus.i_cin : '0);

`ifdef PE_SAT_EN
  logic [ACCW:0] w_ext_sum;
  logic          w_clamp;
  logic          r_sat;

  always_comb begin
    w_ext_sum = {SGN & w_opnd[ACCW-1], w_opnd} + {SGN & w_prodx[ACCW-1], w_prodx};
    w_sum     = w_ext_sum[ACCW-1:0];
    w_clamp   = 1'b0;
    if (SGN) begin
      if (w_ext_sum[ACCW] != w_ext_sum[ACCW-1]) begin
        w_clamp = 1'b1;
        w_sum   = w_ext_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      end
    end else if (w_ext_sum[ACCW]) begin
      w_clamp = 1'b1;
      w_sum   = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (bus.i_ain_val && w_clamp) begin
      r_sat <= 1'b1;
    end
  end

  assign bus.o_sat = r_sat;
`else
  assign w_sum     = w_opnd + w_prodx;
  assign bus.o_sat = 1'b0;
`endif

  // South chain is a shift-load: keep the newest weight, push the displaced one down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) r_bank[i] <= '0;
      r_acc       <= '0;
      r_mode      <= 1'b0;
      r_aout      <= '0;
      r_aout_slot <= '0;
      r_aout_val  <= 1'b0;
      r_aout_last <= 1'b0;
      r_bout      <= '0;
      r_bout_slot <= '0;
      r_bout_val  <= 1'b0;
      r_cout      <= '0;
      r_cout_val  <= 1'b0;
    end else begin
      r_aout      <= bus.i_ain;
      r_aout_slot <= bus.i_ain_slot;
      r_aout_val  <= bus.i_ain_val;
      r_aout_last <= bus.i_ain_last;
      r_bout      <= r_bank[bus.i_bin_slot];
      r_bout_slot <= bus.i_bin_slot;
      r_bout_val  <= bus.i_bin_val;
      if (bus.i_bin_val) r_bank[bus.i_bin_slot] <= bus.i_bin;
      r_mode      <= bus.i_mode;
      r_acc       <= w_acc_eff;
      r_cout_val  <= 1'b0;
      if (!bus.i_mode) begin
        r_acc <= '0;
        if (bus.i_ain_val) begin
          r_cout     <= w_sum;
          r_cout_val <= 1'b1;
        end
      end else if (bus.i_ain_val) begin
        if (bus.i_ain_last) begin
          r_cout     <= w_sum;
          r_cout_val <= 1'b1;
          r_acc      <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end else if (bus.i_cin_val) begin
        r_cout     <= bus.i_cin;
        r_cout_val <= 1'b1;
      end
    end
  end

  assign bus.o_aout      = r_aout;
  assign bus.o_aout_slot = r_aout_slot;
  assign bus.o_aout_val  = r_aout_val;
  assign bus.o_aout_last = r_aout_last;
  assign bus.o_bout      = r_bout;
  assign bus.o_bout_slot = r_bout_slot;
  assign bus.o_bout_val  = r_bout_val;
  assign bus.o_cout      = r_cout;
  assign bus.o_cout_val  = r_cout_val;
endmodule
